// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, ALU encodings,
// state codes and the Moore output decode used by the sequencer.
package cpu_ctrl_pkg;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_LOGIC = 4'b0000;
    localparam logic [3:0] OP_ARITH = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BEQ   = 4'b1111;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } stateT;

    // Per-state control word. The two PC write bits are later qualified by
    // MemReady (fetch) and Zero (branch) outside the register.
    typedef struct packed {
        logic       pcWriteFetch;
        logic       pcWriteBranch;
        logic       pcSource;
        logic       iorD;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       fault;
    } ctrlT;

    // Moore decode; fromR selects RegDst for the ALU writeback state.
    function automatic ctrlT decodeState(stateT s, logic fromR);
        ctrlT c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead      = 1'b1;
                c.aluSrcB      = SRCB_ONE;
                c.irWrite      = 1'b1;
                c.pcWriteFetch = 1'b1;
            end
            S_DECODE:   c.aluSrcB = SRCB_BROFF;
            S_EXEC_R: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_REGB;
                c.aluOp   = ALUOP_FUNCT;
                c.regDst  = 1'b1;
            end
            S_EXEC_I: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_IMM;
            end
            S_WB_ALU: begin
                c.regWrite = 1'b1;
                c.regDst   = fromR;
            end
            S_MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_MEM_WB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
            end
            S_MEM_WR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA       = 1'b1;
                c.aluSrcB       = SRCB_REGB;
                c.aluOp         = ALUOP_SUB;
                c.pcSource      = 1'b1;
                c.pcWriteBranch = 1'b1;
            end
            S_FAULT:    c.fault = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR opcode and status in, selects/enables out.
interface multicycle_control_fsm_if;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCSource;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       Busy;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCSource, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Busy, Fault, State
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCSource, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Busy, Fault, State
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expire flags the last allowed one.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    output logic              expire,
    output logic [WAIT_W-1:0] count
);

    // Wait cycle counter; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + WAIT_W'(1);
    end

    // This wait cycle brings the total to MAX_WAIT
    assign expire = enable && (count == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the 16-bit CPU: fetch/decode/execute/memory/writeback
// with a memory-ready handshake and a sticky timeout fault.
// Optional macro ILLEGAL_OP_TRAP_EN: undefined opcodes trap to FAULT instead of NOP.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    multicycle_control_fsm_if.master bus
);

    stateT             stateQ;
    stateT             nextState;
    ctrlT              ctrlQ;
    logic              inMem;
    logic              waitEn;
    logic              expire;
    logic [WAIT_W-1:0] waitCount;

    // Only these states hold a memory request open
    assign inMem  = (stateQ == S_FETCH) || (stateQ == S_MEM_RD) || (stateQ == S_MEM_WR);
    assign waitEn = inMem && !bus.MemReady;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) uWaitTimer (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (!waitEn),
        .enable (waitEn),
        .expire (expire),
        .count  (waitCount)
    );

    // Next-state selection; MemReady wins over a same-cycle expiry
    always_comb begin
        nextState = stateQ;
        case (stateQ)
            S_FETCH:    if (bus.MemReady) nextState = S_DECODE;
                        else if (expire)  nextState = S_FAULT;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LOGIC, OP_ARITH, OP_SHIFT: nextState = S_EXEC_R;
                    OP_ADDI, OP_SUBI, OP_SLTI:    nextState = S_EXEC_I;
                    OP_LW, OP_SW:                 nextState = S_MEM_ADDR;
                    OP_BEQ:                       nextState = S_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                      nextState = S_FAULT;
`else
                    default:                      nextState = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I: nextState = S_WB_ALU;
            S_WB_ALU:   nextState = S_FETCH;
            S_MEM_ADDR: nextState = (bus.Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.MemReady) nextState = S_MEM_WB;
                        else if (expire)  nextState = S_FAULT;
            S_MEM_WB:   nextState = S_FETCH;
            S_MEM_WR:   if (bus.MemReady) nextState = S_FETCH;
                        else if (expire)  nextState = S_FAULT;
            S_BRANCH:   nextState = S_FETCH;
            S_FAULT:    nextState = S_FAULT;
            default:    nextState = S_FETCH;
        endcase
    end

    // State register plus control word pre-decoded from the next state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ <= S_FETCH;
            ctrlQ  <= decodeState(S_FETCH, 1'b0);
        end else begin
            stateQ <= nextState;
            ctrlQ  <= decodeState(nextState, stateQ == S_EXEC_R);
        end
    end

    // Reset forces every enable and select low so nothing commits mid-reset
    assign bus.PCWrite  = !Reset && ((ctrlQ.pcWriteFetch && bus.MemReady) ||
                                     (ctrlQ.pcWriteBranch && bus.Zero));
    assign bus.IRWrite  = !Reset && ctrlQ.irWrite && bus.MemReady;
    assign bus.PCSource = !Reset && ctrlQ.pcSource;
    assign bus.IorD     = !Reset && ctrlQ.iorD;
    assign bus.MemRead  = !Reset && ctrlQ.memRead;
    assign bus.MemWrite = !Reset && ctrlQ.memWrite;
    assign bus.MemToReg = !Reset && ctrlQ.memToReg;
    assign bus.RegDst   = !Reset && ctrlQ.regDst;
    assign bus.RegWrite = !Reset && ctrlQ.regWrite;
    assign bus.ALUSrcA  = !Reset && ctrlQ.aluSrcA;
    assign bus.ALUSrcB  = Reset ? 2'b00 : ctrlQ.aluSrcB;
    assign bus.ALUOp    = Reset ? 2'b00 : ctrlQ.aluOp;
    assign bus.Fault    = !Reset && ctrlQ.fault;
    assign bus.Busy     = !Reset && !((stateQ == S_FETCH) && (waitCount == '0));
    assign bus.State    = stateQ;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle controller.
module tb_multicycle_control_fsm;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.MAX_WAIT(15), .WAIT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    function automatic logic anyEnable();
        return bus.PCWrite | bus.IRWrite | bus.MemRead | bus.MemWrite | bus.RegWrite;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; bus.MemReady = 1'b1; bus.Opcode = 4'd0; bus.Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.State !== 4'd0 || anyEnable() !== 1'b0 || bus.ALUSrcB !== 2'b00 || bus.Fault !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d] state=%0d en=%0b srcb=%0d fault=%0b exp state=0 en=0 srcb=0 fault=0",
                         i, bus.State, anyEnable(), bus.ALUSrcB, bus.Fault);
            end
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1 || bus.MemRead !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release irw=%0b pcw=%0b mrd=%0b busy=%0b exp 1 1 1 0",
                     bus.IRWrite, bus.PCWrite, bus.MemRead, bus.Busy);
        end
        tick();
        checks++;
        if (bus.State !== 4'd1) begin
            failures++;
            $display("FAIL reset_to_decode got=%0d exp=1", bus.State);
        end
    endtask

    // R-type (exp states 0,1,2,4,0) or I-type (0,1,3,4,0)
    task automatic test_alu(input logic [3:0] op, input logic isR);
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, isR ? 4'd2 : 4'd3, 4'd4, 4'd0};
        doReset();
        bus.Opcode = op; bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.State !== exp[i] || bus.RegWrite !== (i == 3)) begin
                failures++;
                $display("FAIL alu_op%0h[%0d] state=%0d regw=%0b exp state=%0d regw=%0b",
                         op, i, bus.State, bus.RegWrite, exp[i], (i == 3));
            end
            if (i == 2) begin
                checks++;
                if (bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== (isR ? 2'b00 : 2'b10) || bus.ALUOp !== (isR ? 2'b10 : 2'b11)) begin
                    failures++;
                    $display("FAIL alu_exec_op%0h srca=%0b srcb=%0d aluop=%0d exp srca=1 srcb=%0d aluop=%0d",
                             op, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, isR ? 0 : 2, isR ? 2 : 3);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.RegDst !== isR || bus.MemToReg !== 1'b0) begin
                    failures++;
                    $display("FAIL alu_wb_op%0h regdst=%0b memtoreg=%0b exp regdst=%0b memtoreg=0",
                             op, bus.RegDst, bus.MemToReg, isR);
                end
            end
            tick();
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp [9];
        logic       rdy [9];
        exp = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        doReset();
        bus.Opcode = 4'b1100;
        for (int i = 0; i < 9; i++) begin
            bus.MemReady = rdy[i];
            #1;
            checks++;
            if (bus.State !== exp[i]) begin
                failures++;
                $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.State, exp[i]);
            end
            if (exp[i] == 4'd6) begin
                checks++;
                if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1 || bus.RegWrite !== 1'b0) begin
                    failures++;
                    $display("FAIL lw_memrd[%0d] mrd=%0b iord=%0b regw=%0b exp 1 1 0",
                             i, bus.MemRead, bus.IorD, bus.RegWrite);
                end
            end
            if (i == 7) begin
                checks++;
                if (bus.RegWrite !== 1'b1 || bus.MemToReg !== 1'b1 || bus.RegDst !== 1'b0) begin
                    failures++;
                    $display("FAIL lw_memwb regw=%0b memtoreg=%0b regdst=%0b exp 1 1 0",
                             bus.RegWrite, bus.MemToReg, bus.RegDst);
                end
            end
            tick();
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd0};
        doReset();
        bus.Opcode = 4'b1101; bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.State !== exp[i] || bus.MemWrite !== (i == 3)) begin
                failures++;
                $display("FAIL sw[%0d] state=%0d mwr=%0b exp state=%0d mwr=%0b",
                         i, bus.State, bus.MemWrite, exp[i], (i == 3));
            end
            if (i == 2) begin
                checks++;
                if (bus.ALUSrcB !== 2'b10 || bus.ALUOp !== 2'b00 || bus.ALUSrcA !== 1'b1) begin
                    failures++;
                    $display("FAIL sw_addr srcb=%0d aluop=%0d srca=%0b exp 2 0 1", bus.ALUSrcB, bus.ALUOp, bus.ALUSrcA);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch(input logic z);
        logic [3:0] exp [4];
        exp = '{4'd0, 4'd1, 4'd9, 4'd0};
        doReset();
        bus.Opcode = 4'b1111; bus.MemReady = 1'b1; bus.Zero = z;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.State !== exp[i]) begin
                failures++;
                $display("FAIL beq_z%0b_state[%0d] got=%0d exp=%0d", z, i, bus.State, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (bus.PCWrite !== 1'b0 || bus.ALUSrcB !== 2'b11) begin
                    failures++;
                    $display("FAIL beq_decode pcw=%0b srcb=%0d exp 0 3", bus.PCWrite, bus.ALUSrcB);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.PCWrite !== z || bus.PCSource !== 1'b1 || bus.ALUOp !== 2'b01) begin
                    failures++;
                    $display("FAIL beq_z%0b pcw=%0b pcsrc=%0b aluop=%0d exp pcw=%0b pcsrc=1 aluop=1",
                             z, bus.PCWrite, bus.PCSource, bus.ALUOp, z);
                end
            end
            tick();
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_timeout();
        doReset();
        bus.Opcode = 4'd0; bus.MemReady = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if (bus.State !== 4'd0 || bus.Fault !== 1'b0 || bus.Busy !== (i != 0)) begin
                failures++;
                $display("FAIL timeout_wait[%0d] state=%0d fault=%0b busy=%0b exp 0 0 %0b",
                         i, bus.State, bus.Fault, bus.Busy, (i != 0));
            end
            tick();
        end
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.State !== 4'd15 || bus.Fault !== 1'b1 || anyEnable() !== 1'b0) begin
                failures++;
                $display("FAIL timeout_fault[%0d] state=%0d fault=%0b en=%0b exp 15 1 0",
                         i, bus.State, bus.Fault, anyEnable());
            end
            tick();
        end
        doReset();
        #1;
        checks++;
        if (bus.State !== 4'd0 || bus.Fault !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear state=%0d fault=%0b exp 0 0", bus.State, bus.Fault);
        end
    endtask

    // Ready on the 15th wait-eligible cycle beats the timeout
    task automatic test_ready_at_limit();
        doReset();
        bus.Opcode = 4'd0; bus.MemReady = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        bus.MemReady = 1'b1;
        tick();
        checks++;
        if (bus.State !== 4'd1 || bus.Fault !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_limit state=%0d fault=%0b exp 1 0", bus.State, bus.Fault);
        end
    endtask

    task automatic test_illegal();
        doReset();
        bus.Opcode = 4'b0111; bus.MemReady = 1'b1;
        tick();
        tick();
        checks++;
`ifdef ILLEGAL_OP_TRAP_EN
        if (bus.State !== 4'd15 || bus.Fault !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op state=%0d fault=%0b exp 15 1", bus.State, bus.Fault);
        end
`else
        if (bus.State !== 4'd0 || bus.Fault !== 1'b0) begin
            failures++;
            $display("FAIL illegal_op state=%0d fault=%0b exp 0 0", bus.State, bus.Fault);
        end
`endif
    endtask

    // Reset asserted while a store waits: write drops immediately, next is FETCH
    task automatic test_reset_mid();
        doReset();
        bus.Opcode = 4'b1101; bus.MemReady = 1'b1;
        tick(); tick(); tick();
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if (bus.State !== 4'd8 || bus.MemWrite !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre state=%0d mwr=%0b exp 8 1", bus.State, bus.MemWrite);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.IorD !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_gate mwr=%0b iord=%0b exp 0 0", bus.MemWrite, bus.IorD);
        end
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_post state=%0d mwr=%0b exp 0 0", bus.State, bus.MemWrite);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        bus.Opcode = 4'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        #2;
        test_reset();
        test_alu(4'b0001, 1'b1);
        test_alu(4'b1001, 1'b0);
        test_lw();
        test_sw();
        test_branch(1'b1);
        test_branch(1'b0);
        test_timeout();
        test_ready_at_limit();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
